instruction_encoder: RTL and testbench
======================================

// Module: instruction_encoder
// PURPOSE
//  Streaming RV32I instruction encoder; the inverse of the core's immediate/field decode path.
//  Accepts decoded fields (opcode, funct, registers, 32-bit immediate) on a valid/ready input.
//  Emits one packed 32-bit instruction word per accepted beat on a valid/ready output.
//  Each output word carries an auto-incrementing memory address, for loading instruction memory
//  (self-test/boot program writer) without an external assembler.
// PARAMETERS
//  BASE_ADDR   32'h0000_0000  address of first emitted word after reset or start_i
//  CNT_WIDTH   16             width of emitted-word counter
// PORTS
//  clk          in   1          single clock, rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  start_i      in   1          sync pulse: reload address to BASE_ADDR, clear counter and sticky error
//  in_valid_i   in   1          field beat valid
//  in_ready_o   out  1          encoder can accept beat
//  opcode_i     in   7          opcode; selects format
//  funct3_i     in   3          funct3 (ignored for U/J)
//  funct7_i     in   7          funct7 (R only)
//  rd_i         in   5          destination register (ignored for S/B)
//  rs1_i        in   5          source 1 (ignored for U/J)
//  rs2_i        in   5          source 2 (R/S/B only)
//  imm_i        in   32         full signed immediate as the decoder would return it
//  out_valid_o  out  1          instr_o/addr_o/err_o valid
//  out_ready_i  in   1          sink accepts word
//  instr_o      out  32         encoded instruction
//  addr_o       out  32         byte address of instr_o
//  err_o        out  1          this word had a range/alignment/opcode error
//  err_sticky_o out  1          any error since reset/start_i
//  count_o      out  CNT_WIDTH  words accepted by sink since reset/start_i (wraps)
// BEHAVIOUR
//  Reset: out_valid_o=0, instr_o=0, addr_o=BASE_ADDR, err_o=0, err_sticky_o=0, count_o=0.
//  Formats by opcode: 0110011 R; 0010011/0000011/1100111 I; 0100011 S; 1100011 B;
//   0110111/0010111 U; 1101111 J. Bit placement is exact RV32I inverse of immediate extraction.
//  Range rules (error => err_o=1, word still encoded from truncated bits):
//   I,S: imm in [-2048,2047]. B: [-4096,4094], imm[0]=0. J: [-2^20, 2^20-2], imm[0]=0.
//   U: imm[11:0]==0.
//  Unknown opcode: err_o=1, instr_o=32'h0000_0013 (NOP).
//  Pipeline: single output register, latency 1 cycle from accepted input to out_valid_o.
//   in_ready_o = !out_valid_o || out_ready_i (combinational; full throughput, no bubbles).
//  Output held stable while out_valid_o && !out_ready_i; no word dropped or duplicated.
//  On output handshake: addr_o += 4 (wraps mod 2^32), count_o += 1 (wraps).
//   err_sticky_o |= err_o, evaluated at output handshake.
//  start_i: flushes the output register (out_valid_o=0) and applies reset values next cycle.
//   Same-cycle input beat is dropped and in_ready_o=0 during start_i.
//   start_i has priority over any simultaneous handshake.
//  Async reset mid-stream: all state cleared immediately; in-flight word lost.
// STRUCTURE
//  Shared package (rv32i_pkg): opcode localparams (LW, SW, JAL, LUI, JALR, AUIPC, BRANCH,
//   IMMEDIATE, R-type) and format enum (FMT_R/I/S/B/U/J/BAD), shared with the decode side.
//  Sub-module: instr_pack (combinational fields -> {word, err}); top holds pipeline register,
//   address counter, word counter and sticky error.
// TESTING
//  addi x1,x0,5 (0010011,f3=0,rd=1,rs1=0,imm=5) -> instr_o=32'h00500093, addr_o=BASE, err_o=0.
//  sw x2,8(x1) then lui x5,0x12345000 back-to-back -> 32'h0020A423 @0, 32'h123452B7 @4.
//   One word per cycle, no bubbles.
//  jal x1,-4 -> 32'hFFDFF0EF; beq imm=3 -> err_o=1, err_sticky_o=1; opcode 7'h7F -> NOP, err_o=1.
//  out_ready_i low 3 cycles with input valid -> instr_o stable, in_ready_o=0.
//   After release, all words arrive in order; count_o matches beats.
//  Random legal fields: decoding instr_o with the core's immediate generator returns imm_i.
//   rd/rs1/rs2/funct fields match inputs.
//  rst_n low mid-stream, then start_i after errors -> addr_o=BASE, count_o=0, err_sticky_o=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// RV32I opcodes and instruction formats, shared by the encode and decode paths.
package rv32i_pkg;

  localparam logic [6:0] OP_LW        = 7'b0000011;
  localparam logic [6:0] OP_SW        = 7'b0100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_IMMEDIATE = 7'b0010011;
  localparam logic [6:0] OP_RTYPE     = 7'b0110011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  function automatic fmt_e get_fmt(input logic [6:0] opcode);
    case (opcode)
      OP_RTYPE:                      return FMT_R;
      OP_IMMEDIATE, OP_LW, OP_JALR:  return FMT_I;
      OP_SW:                         return FMT_S;
      OP_BRANCH:                     return FMT_B;
      OP_LUI, OP_AUIPC:              return FMT_U;
      OP_JAL:                        return FMT_J;
      default:                       return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: decoded fields -> RV32I word plus range/alignment/opcode error.
module instr_pack
  import rv32i_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err
);

  // An immediate fits when every bit above its sign bit repeats the sign bit.
  logic fits12, fits13, fits21;
  assign fits12 = (imm[31:11] == {21{imm[11]}});
  assign fits13 = (imm[31:12] == {20{imm[12]}});
  assign fits21 = (imm[31:20] == {12{imm[20]}});

  always_comb begin
    word = NOP_WORD;
    err  = 1'b0;
    case (get_fmt(opcode))
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
        err  = !fits12;
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = !fits12;
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = !fits13 || imm[0];
      end
      FMT_U: begin
        word = {imm[31:12], rd, opcode};
        err  = (imm[11:0] != 12'h000);
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = !fits21 || imm[0];
      end
      default: begin
        word = NOP_WORD;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Streaming RV32I encoder: one output register with address, word counter and sticky error.
module instruction_encoder
  import rv32i_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [6:0]           opcode_i,
  input  logic [2:0]           funct3_i,
  input  logic [6:0]           funct7_i,
  input  logic [4:0]           rd_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [31:0]          imm_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          instr_o,
  output logic [31:0]          addr_o,
  output logic                 err_o,
  output logic                 err_sticky_o,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [31:0] pack_word;
  logic        pack_err;
  logic        accept;
  logic        out_hs;

  instr_pack u_pack (
    .opcode (opcode_i),
    .funct3 (funct3_i),
    .funct7 (funct7_i),
    .rd     (rd_i),
    .rs1    (rs1_i),
    .rs2    (rs2_i),
    .imm    (imm_i),
    .word   (pack_word),
    .err    (pack_err)
  );

  assign in_ready_o = !start_i && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign out_hs     = out_valid_o && out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o  <= 1'b0;
      instr_o      <= '0;
      addr_o       <= BASE_ADDR;
      err_o        <= 1'b0;
      err_sticky_o <= 1'b0;
      count_o      <= '0;
    end else if (start_i) begin
      out_valid_o  <= 1'b0;
      instr_o      <= '0;
      addr_o       <= BASE_ADDR;
      err_o        <= 1'b0;
      err_sticky_o <= 1'b0;
      count_o      <= '0;
    end else begin
      // addr_o advances on the handshake, so a word loaded in the same cycle gets the next address.
      if (out_hs) begin
        addr_o       <= addr_o + 32'd4;
        count_o      <= count_o + CNT_WIDTH'(1);
        err_sticky_o <= err_sticky_o | err_o;
      end
      if (accept) begin
        out_valid_o <= 1'b1;
        instr_o     <= pack_word;
        err_o       <= pack_err;
      end else if (out_hs) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: directed vectors plus decode-back of legal fields.
module tb_instruction_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [6:0]  funct7_i = '0;
  logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
  logic [31:0] imm_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] instr_o, addr_o;
  logic        err_o, err_sticky_o;
  logic [15:0] count_o;

  instruction_encoder #(.BASE_ADDR(BASE), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .instr_o(instr_o), .addr_o(addr_o), .err_o(err_o),
    .err_sticky_o(err_sticky_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    bit          dec;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } exp_t;

  exp_t        sb[$];
  int          hs_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_addr = BASE;
  logic [15:0] exp_count = '0;
  logic        exp_sticky = 1'b0;
  int          beats = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Immediate generator of the decode side, used to close the loop on legal fields.
  function automatic bit decode_ok(input exp_t e, input logic [31:0] w);
    logic [31:0] im;
    bit ok;
    ok = (w[6:0] == e.op);
    case (e.op)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        im = {{20{w[31]}}, w[31:20]};
        ok = ok && w[11:7] == e.rd && w[14:12] == e.f3 && w[19:15] == e.rs1;
      end
      7'b0100011: begin
        im = {{20{w[31]}}, w[31:25], w[11:7]};
        ok = ok && w[14:12] == e.f3 && w[19:15] == e.rs1 && w[24:20] == e.rs2;
      end
      7'b1100011: begin
        im = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        ok = ok && w[14:12] == e.f3 && w[19:15] == e.rs1 && w[24:20] == e.rs2;
      end
      7'b0110111, 7'b0010111: begin
        im = {w[31:12], 12'h000};
        ok = ok && w[11:7] == e.rd;
      end
      7'b1101111: begin
        im = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        ok = ok && w[11:7] == e.rd;
      end
      default: begin
        im = e.imm;
        ok = ok && w[31:25] == e.f7 && w[24:20] == e.rs2 && w[19:15] == e.rs1 &&
             w[14:12] == e.f3 && w[11:7] == e.rd;
      end
    endcase
    return ok && (im == e.imm);
  endfunction

  always @(negedge clk) begin
    if (rst_n && !start_i && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_word", instr_o, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.dec) check("decode_back", {31'd0, decode_ok(e, instr_o)}, 32'd1);
        else       check("instr", instr_o, e.instr);
        check("addr", addr_o, exp_addr);
        check("err", {31'd0, err_o}, {31'd0, e.err});
        check("count", {16'd0, count_o}, {16'd0, exp_count});
        check("sticky", {31'd0, err_sticky_o}, {31'd0, exp_sticky});
        hs_cyc.push_back(cyc);
        exp_addr   = exp_addr + 32'd4;
        exp_count  = exp_count + 16'd1;
        exp_sticky = exp_sticky | e.err;
      end
    end
  end

  task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm);
    opcode_i = op; funct3_i = f3; funct7_i = f7;
    rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
  endtask

  // Called just after a posedge; returns just after the posedge that accepted the beat.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] ew, input logic ee,
                      input bit dec);
    exp_t e;
    bit got;
    set_fields(op, f3, f7, rd, rs1, rs2, imm);
    in_valid_i = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready_o;
    end
    if (!got) begin
      check("in_ready_timeout", {31'd0, in_ready_o}, 32'd1);
      in_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    e = '{instr: ew, err: ee, dec: dec, op: op, f3: f3, f7: f7,
          rd: rd, rs1: rs1, rs2: rs2, imm: imm};
    sb.push_back(e);
    beats++;
    #1 in_valid_i = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !out_valid_o;
    end
    if (!done) check("drain_timeout", {31'd0, out_valid_o}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    sb.delete();
    exp_addr = BASE; exp_count = '0; exp_sticky = 1'b0; beats = 0;
  endtask

  initial begin
    int v;
    logic [31:0] im;
    #12;
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_addr", addr_o, BASE);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_sticky", {31'd0, err_sticky_o}, 32'd0);
    check("rst_count", {16'd0, count_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0, 0);
    drain();

    hs_cyc.delete();
    send(7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b0, 0);
    send(7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0, 0);
    drain();
    if (hs_cyc.size() == 2) check("no_bubble", hs_cyc[1] - hs_cyc[0], 32'd1);
    else check("no_bubble_words", hs_cyc.size(), 32'd2);

    send(7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFFDFF0EF, 1'b0, 0);
    send(7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h000F_FFFE, 32'h7FFFF0EF, 1'b0, 0);
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h80000093, 1'b0, 0);
    send(7'b0110011, 3'd0, 7'h20, 5'd5, 5'd6, 5'd7, 32'd0, 32'h407302B3, 1'b0, 0);
    drain();
    check("sticky_clean", {31'd0, err_sticky_o}, 32'd0);

    send(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 32'h00208163, 1'b1, 0);
    drain();
    check("sticky_after_beq", {31'd0, err_sticky_o}, 32'd1);
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h80000093, 1'b1, 0);
    send(7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'h800000EF, 1'b1, 0);
    send(7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, 32'h123452B7, 1'b1, 0);
    send(7'h7F, 3'd5, 7'h11, 5'd9, 5'd3, 5'd4, 32'h1234, 32'h00000013, 1'b1, 0);
    drain();

    out_ready_i = 1'b0;
    send(7'b0010011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd0, 32'hFFFF_FFFF, 32'hFFF08193, 1'b0, 0);
    set_fields(7'b0000011, 3'd2, 7'd0, 5'd4, 5'd2, 5'd0, 32'd4);
    in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready_o}, 32'd0);
      check("stall_hold", instr_o, 32'hFFF08193);
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    send(7'b0000011, 3'd2, 7'd0, 5'd4, 5'd2, 5'd0, 32'd4, 32'h00412203, 1'b0, 0);
    send(7'b0110011, 3'd0, 7'd0, 5'd5, 5'd6, 5'd7, 32'd0, 32'h007302B3, 1'b0, 0);
    drain();
    check("count_total", {16'd0, count_o}, beats);

    for (int n = 0; n < 20; n++) begin
      case (n % 5)
        0: begin v = int'($urandom_range(0, 4095)) - 2048; im = v;
           send(7'b0010011, 3'($urandom), 7'd0, 5'($urandom), 5'($urandom), 5'd0, im, '0, 1'b0, 1); end
        1: begin v = int'($urandom_range(0, 4095)) - 2048; im = v;
           send(7'b0100011, 3'($urandom), 7'd0, 5'd0, 5'($urandom), 5'($urandom), im, '0, 1'b0, 1); end
        2: begin v = (int'($urandom_range(0, 4095)) - 2048) * 2; im = v;
           send(7'b1100011, 3'($urandom), 7'd0, 5'd0, 5'($urandom), 5'($urandom), im, '0, 1'b0, 1); end
        3: begin v = (int'($urandom_range(0, 1048575)) - 524288) * 2; im = v;
           send(7'b1101111, 3'd0, 7'd0, 5'($urandom), 5'd0, 5'd0, im, '0, 1'b0, 1); end
        default: begin im = $urandom & 32'hFFFF_F000;
           send(7'b0010111, 3'd0, 7'd0, 5'($urandom), 5'd0, 5'd0, im, '0, 1'b0, 1); end
      endcase
    end
    drain();

    out_ready_i = 1'b0;
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0, 0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("arst_addr", addr_o, BASE);
    check("arst_count", {16'd0, count_o}, 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b1;

    send(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 32'h00208163, 1'b1, 0);
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0, 0);
    drain();
    check("sticky_before_start", {31'd0, err_sticky_o}, 32'd1);
    out_ready_i = 1'b0;
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7, 32'h00700093, 1'b0, 0);
    start_i = 1'b1;
    in_valid_i = 1'b1;
    @(negedge clk);
    check("start_in_ready", {31'd0, in_ready_o}, 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    in_valid_i = 1'b0;
    model_reset();
    @(negedge clk);
    check("start_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("start_addr", addr_o, BASE);
    check("start_count", {16'd0, count_o}, 32'd0);
    check("start_sticky", {31'd0, err_sticky_o}, 32'd0);
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    send(7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0, 0);
    drain();
    check("final_count", {16'd0, count_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
